// File: rtl/wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master-side ports, the shared
// slave-side port, and the grant/timeout status. The arbiter uses the slave modport.
interface wb_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 8
);
  logic              i_m0_cyc;
  logic              i_m0_stb;
  logic              i_m0_rw;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [DATA_W-1:0] i_m0_dat;
  logic              o_m0_ack;
  logic [DATA_W-1:0] o_m0_dat;

  logic              i_m1_cyc;
  logic              i_m1_stb;
  logic              i_m1_rw;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [DATA_W-1:0] i_m1_dat;
  logic              o_m1_ack;
  logic [DATA_W-1:0] o_m1_dat;

  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_rw;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [DATA_W-1:0] o_wb_dat;
  logic              i_wb_ack;
  logic [DATA_W-1:0] i_wb_dat;

  logic [1:0]        o_grant;
  logic              o_timeout;

  modport slave (
    input  i_m0_cyc, i_m0_stb, i_m0_rw, i_m0_addr, i_m0_dat,
    output o_m0_ack, o_m0_dat,
    input  i_m1_cyc, i_m1_stb, i_m1_rw, i_m1_addr, i_m1_dat,
    output o_m1_ack, o_m1_dat,
    output o_wb_cyc, o_wb_stb, o_wb_rw, o_wb_addr, o_wb_dat,
    input  i_wb_ack, i_wb_dat,
    output o_grant, o_timeout
  );

  modport master (
    output i_m0_cyc, i_m0_stb, i_m0_rw, i_m0_addr, i_m0_dat,
    input  o_m0_ack, o_m0_dat,
    output i_m1_cyc, i_m1_stb, i_m1_rw, i_m1_addr, i_m1_dat,
    input  o_m1_ack, o_m1_dat,
    input  o_wb_cyc, o_wb_stb, o_wb_rw, o_wb_addr, o_wb_dat,
    output i_wb_ack, i_wb_dat,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter; grant held for the whole cyc period.
// Optional stalled-strobe watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic              own_chg;
  logic              to_q;

  logic              cyc_s, stb_s, rw_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdat_s;
  logic              ack0_s, ack1_s;
  logic [DATA_W-1:0] rdat0_s, rdat1_s;

  // Watchdog below one cycle of headroom is meaningless; no logic hangs off this.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_m0_cyc && (!bus.i_m1_cyc || last_q)) state_d = OWN0;
        else if (bus.i_m1_cyc)                         state_d = OWN1;
      end
      OWN0: if (!bus.i_m0_cyc) state_d = bus.i_m1_cyc ? OWN1 : IDLE;
      OWN1: if (!bus.i_m1_cyc) state_d = bus.i_m0_cyc ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
    own_chg = (state_d != state_q);
    if (own_chg) begin
      grant_d = 2'b00;
      if (state_d == OWN0) begin
        last_d  = 1'b0;
        grant_d = 2'b01;
      end else if (state_d == OWN1) begin
        last_d  = 1'b1;
        grant_d = 2'b10;
      end
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;

  // stb_s is already forced low during the termination cycle, so the count restarts there.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (own_chg || !stb_s || bus.i_wb_ack) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        to_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign to_q = 1'b0;
`endif

  // Read data is broadcast while owned; idle outputs stay at zero.
  always_comb begin
    cyc_s   = 1'b0;
    stb_s   = 1'b0;
    rw_s    = 1'b0;
    addr_s  = '0;
    wdat_s  = '0;
    ack0_s  = 1'b0;
    ack1_s  = 1'b0;
    rdat0_s = '0;
    rdat1_s = '0;
    unique case (state_q)
      OWN0: begin
        cyc_s   = bus.i_m0_cyc & ~to_q;
        stb_s   = bus.i_m0_stb & ~to_q;
        rw_s    = bus.i_m0_rw;
        addr_s  = bus.i_m0_addr;
        wdat_s  = bus.i_m0_dat;
        ack0_s  = to_q | bus.i_wb_ack;
        rdat0_s = to_q ? '1 : bus.i_wb_dat;
        rdat1_s = bus.i_wb_dat;
      end
      OWN1: begin
        cyc_s   = bus.i_m1_cyc & ~to_q;
        stb_s   = bus.i_m1_stb & ~to_q;
        rw_s    = bus.i_m1_rw;
        addr_s  = bus.i_m1_addr;
        wdat_s  = bus.i_m1_dat;
        ack1_s  = to_q | bus.i_wb_ack;
        rdat1_s = to_q ? '1 : bus.i_wb_dat;
        rdat0_s = bus.i_wb_dat;
      end
      default: ;
    endcase
  end

  assign bus.o_wb_cyc  = cyc_s;
  assign bus.o_wb_stb  = stb_s;
  assign bus.o_wb_rw   = rw_s;
  assign bus.o_wb_addr = addr_s;
  assign bus.o_wb_dat  = wdat_s;
  assign bus.o_m0_ack  = ack0_s;
  assign bus.o_m1_ack  = ack1_s;
  assign bus.o_m0_dat  = rdat0_s;
  assign bus.o_m1_dat  = rdat1_s;
  assign bus.o_grant   = grant_q;
  assign bus.o_timeout = to_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration, handover, ack routing, async reset, stall.
module tb_wb_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0; bus.i_m0_rw = 1'b0;
    bus.i_m0_addr = '0;  bus.i_m0_dat = '0;
    bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0; bus.i_m1_rw = 1'b0;
    bus.i_m1_addr = '0;  bus.i_m1_dat = '0;
    bus.i_wb_ack = 1'b0; bus.i_wb_dat = '0;
  endtask

  initial begin
    clear_inputs();
    settle();
    chk("rst_grant",   32'(bus.o_grant), 32'h0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'h0);
    chk("rst_wb_ctl",  32'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_rw}), 32'h0);
    chk("rst_acks",    32'({bus.o_m0_ack, bus.o_m1_ack}), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Master 1 alone reads 0x000123, slave acks two cycles after stb.
    tick();
    bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1; bus.i_m1_rw = 1'b1; bus.i_m1_addr = 24'h000123;
    settle();
    chk("t1_idle_grant", 32'(bus.o_grant), 32'h0);
    chk("t1_idle_stb",   32'(bus.o_wb_stb), 32'h0);
    tick();
    chk("t1_grant",  32'(bus.o_grant), 32'h2);
    chk("t1_stb",    32'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_rw}), 32'h7);
    chk("t1_addr",   32'(bus.o_wb_addr), 32'h000123);
    chk("t1_noack",  32'(bus.o_m1_ack), 32'h0);
    tick();
    tick();
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 8'hA5;
    settle();
    chk("t1_m1_ack", 32'(bus.o_m1_ack), 32'h1);
    chk("t1_m1_dat", 32'(bus.o_m1_dat), 32'hA5);
    chk("t1_m0_ack", 32'(bus.o_m0_ack), 32'h0);
    tick();
    bus.i_wb_ack = 1'b0; bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
    settle();
    chk("t1_release_ack", 32'(bus.o_m1_ack), 32'h0);
    chk("t1_release_cyc", 32'(bus.o_wb_cyc), 32'h0);
    tick();
    chk("t1_idle_again", 32'(bus.o_grant), 32'h0);

    // Simultaneous requests: master 0 first, direct handover, then alternation.
    clear_inputs();
    bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
    tick();
    chk("t2_tie_m0", 32'(bus.o_grant), 32'h1);
    chk("t2_nostb",  32'(bus.o_wb_stb), 32'h0);
    tick();
    chk("t2_hold_m0", 32'(bus.o_grant), 32'h1);
    bus.i_m0_cyc = 1'b0;
    settle();
    chk("t2_handover_quiet", 32'({bus.o_wb_cyc, bus.o_wb_stb}), 32'h0);
    tick();
    chk("t2_handover_m1", 32'(bus.o_grant), 32'h2);
    bus.i_m1_cyc = 1'b0;
    tick();
    chk("t2_idle", 32'(bus.o_grant), 32'h0);
    bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
    tick();
    chk("t2_tie_again_m0", 32'(bus.o_grant), 32'h1);
    bus.i_m0_cyc = 1'b0; bus.i_m1_cyc = 1'b0;
    tick();
    chk("t2_idle2", 32'(bus.o_grant), 32'h0);
    bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
    tick();
    chk("t2_tie_after_m0_m1", 32'(bus.o_grant), 32'h2);
    bus.i_m0_cyc = 1'b0; bus.i_m1_cyc = 1'b0;
    tick();
    chk("t2_idle3", 32'(bus.o_grant), 32'h0);

    // Master 0 writes while master 1 strobes; master 1 must wait without ack.
    bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_rw = 1'b0;
    bus.i_m0_addr = 24'h00FF00; bus.i_m0_dat = 8'h3C;
    bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1; bus.i_m1_rw = 1'b1;
    bus.i_m1_addr = 24'h000777; bus.i_m1_dat = 8'h55;
    tick();
    chk("t3_grant_m0", 32'(bus.o_grant), 32'h1);
    chk("t3_addr",     32'(bus.o_wb_addr), 32'h00FF00);
    chk("t3_wdat",     32'(bus.o_wb_dat), 32'h3C);
    chk("t3_ctl",      32'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_rw}), 32'h6);
    bus.i_wb_ack = 1'b1;
    settle();
    chk("t3_acks", 32'({bus.o_m1_ack, bus.o_m0_ack}), 32'h1);
    tick();
    bus.i_wb_ack = 1'b0; bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
    settle();
    chk("t3_gap_stb", 32'(bus.o_wb_stb), 32'h0);
    tick();
    chk("t3_grant_m1", 32'(bus.o_grant), 32'h2);
    chk("t3_m1_addr",  32'(bus.o_wb_addr), 32'h000777);
    chk("t3_m1_rw",    32'(bus.o_wb_rw), 32'h1);
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 8'h5A;
    settle();
    chk("t3_m1_acks", 32'({bus.o_m1_ack, bus.o_m0_ack}), 32'h2);
    chk("t3_m1_dat",  32'(bus.o_m1_dat), 32'h5A);
    tick();
    clear_inputs();
    tick();
    chk("t3_idle", 32'(bus.o_grant), 32'h0);

    // Asynchronous reset in the middle of a master 0 read.
    bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_rw = 1'b1; bus.i_m0_addr = 24'h000042;
    tick();
    chk("t4_owned", 32'({bus.o_grant, bus.o_wb_stb}), 32'h3);
    bus.i_wb_dat = 8'hA5; bus.i_wb_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_grant",  32'(bus.o_grant), 32'h0);
    chk("t4_wb_ctl", 32'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_rw}), 32'h0);
    chk("t4_addr",   32'(bus.o_wb_addr), 32'h0);
    chk("t4_m_ack",  32'({bus.o_m0_ack, bus.o_m1_ack}), 32'h0);
    chk("t4_m_dat",  32'({bus.o_m0_dat, bus.o_m1_dat}), 32'h0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_after_grant", 32'(bus.o_grant), 32'h0);
    chk("t4_after_to",    32'(bus.o_timeout), 32'h0);

    // Stalled slave with master 1 waiting.
    bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_rw = 1'b1; bus.i_m0_addr = 24'h000010;
    bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
    bus.i_wb_dat = 8'h11;
    tick();
    chk("t5_grant_m0", 32'(bus.o_grant), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("t5_stall", 32'({bus.o_m0_ack, bus.o_timeout, bus.o_wb_stb}), 32'h1);
      tick();
    end
    bus.i_wb_ack = 1'b1;
    settle();
    chk("t5_term_bus",  32'({bus.o_wb_cyc, bus.o_wb_stb}), 32'h0);
    chk("t5_term_ack",  32'({bus.o_m1_ack, bus.o_m0_ack}), 32'h1);
    chk("t5_term_dat",  32'(bus.o_m0_dat), 32'hFF);
    chk("t5_term_to",   32'(bus.o_timeout), 32'h1);
    bus.i_wb_ack = 1'b0; bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
    tick();
    chk("t5_to_pulse", 32'(bus.o_timeout), 32'h0);
    chk("t5_grant_m1", 32'(bus.o_grant), 32'h2);
    chk("t5_m1_stb",   32'(bus.o_wb_stb), 32'h1);
`else
    for (int i = 0; i < 1000; i++) begin
      chk("t5_hold", 32'({bus.o_m0_ack, bus.o_timeout, bus.o_wb_stb, bus.o_grant}), 32'h5);
      tick();
    end
    bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
    tick();
    chk("t5_grant_m1", 32'(bus.o_grant), 32'h2);
`endif
    clear_inputs();
    tick();
    chk("t5_idle", 32'(bus.o_grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter for the 24-bit-address, 8-bit-data debug/system bus. It shares one slave-side bus between the CPU core (master 0) and the UART-to-Wishbone debug bridge (master 1), so the host can peek and poke memory while the CPU runs. Arbitration is round-robin, and a grant is held for the whole `cyc` period. An optional watchdog terminates bus cycles that stall.

## Interface
Parameters:
- `ADDR_W`, 24, address width
- `DATA_W`, 8, data width
- `TIMEOUT_CYCLES`, 256, stalled-strobe cycles before forced termination (≥2; used only with the watchdog)

Ports:
- `i_wb_clk` in 1: sole clock, all logic on rising edge
- `i_wb_rst_n` in 1: asynchronous, active-low reset
- `i_m0_cyc`, `i_m0_stb`, `i_m0_rw` in 1 each: master 0 cycle, strobe, read(1)/write(0)
- `i_m0_addr` in ADDR_W, `i_m0_dat` in DATA_W: master 0 address, write data
- `o_m0_ack` out 1, `o_m0_dat` out DATA_W: master 0 acknowledge, read data
- `i_m1_*` / `o_m1_*`: identical set for master 1
- `o_wb_cyc`, `o_wb_stb`, `o_wb_rw` out 1: slave-side control
- `o_wb_addr` out ADDR_W, `o_wb_dat` out DATA_W: slave-side address, write data
- `i_wb_ack` in 1, `i_wb_dat` in DATA_W: slave acknowledge, read data
- `o_grant` out 2: one-hot current owner (bit n = master n), 0 when idle
- `o_timeout` out 1: one-cycle pulse on watchdog termination

## Operation
- States:
  - IDLE
  - OWN0
  - OWN1
  - register `last` (1 bit): last owner, reset 1, so master 0 wins the first tie
- IDLE:
  - only one `cyc` high → go to that master's OWN state
  - both high → grant `~last`
  - neither → stay
- OWNn:
  - entering OWNn sets `last <= n`
  - stay while `i_mn_cyc` high
  - on `i_mn_cyc` low: if the other master's `cyc` is high, go directly to that OWN state; else go to IDLE
- Slave-side mux (combinational from state):
  - in OWNn, `o_wb_cyc/stb/rw/addr/dat` = master n's inputs
  - in IDLE, all zero
- Ack routing:
  - `o_mn_ack` = `i_wb_ack` & (state==OWNn)
  - the non-owner never sees ack
- Read data:
  - `o_m0_dat` = `o_m1_dat` = `i_wb_dat` (broadcast)
  - in watchdog termination, the owner's data is forced to all-ones instead
- Slave is never strobed in IDLE.
- Slave is never strobed in a cycle where ownership changes.
- A non-owner's `stb` is ignored; it waits with no ack.
- Reset assertion, asynchronous, at any time including mid-transfer:
  - state → IDLE, `last` → 1, watchdog counter → 0, `o_timeout` → 0
  - all outputs go 0 immediately
  - an in-flight slave cycle is abandoned

## Timing
- Arbitration latency: one cycle. `cyc` rising at edge N → OWN registered at edge N+1 → slave strobe visible after N+1.
- Handover: owner's `cyc` sampled low at edge N → other master owns after edge N. No dead cycle when the other master is already waiting.
- Ack/data path is combinational slave→master, with zero added latency. Master 1 deasserts `stb`/`cyc` the cycle after ack, and the arbiter tolerates that.
- A master holding `cyc` with `stb` low keeps the grant. No fairness preemption.
- Output reset values:
  - `o_grant`=0, `o_timeout`=0
  - all `o_wb_*`=0
  - `o_m*_ack`=0

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - counter of width $clog2(TIMEOUT_CYCLES)+1 increments each cycle `o_wb_stb`=1 and `i_wb_ack`=0; it clears on ack, on ownership change, or when `stb` is low.
  - On reaching TIMEOUT_CYCLES−1 with no ack, the next cycle:
    - forces `o_wb_stb`/`o_wb_cyc` low
    - asserts owner `o_mn_ack`=1 with `o_mn_dat`=all-ones
    - pulses `o_timeout`
  - The counter clears after termination.
  - A real `i_wb_ack` arriving in the termination cycle is ignored.
- Undefined: no counter, `o_timeout` tied 0, and a stalled slave holds the bus forever.

## Test plan
- Master 1 alone reads 0x000123, slave acks 2 cycles after stb with 0xA5 → `o_grant`=2'b10 one cycle after `cyc`; `o_m1_ack` once with `o_m1_dat`=0xA5; `o_m0_ack` stays 0.
- Both `cyc` rise at the same edge after reset → master 0 owns first. After master 0 drops `cyc`, master 1 owns on the same edge with no IDLE cycle. Next tie goes to master 0 again (`last`=1).
- Master 0 writes 0x3C to 0x00FF00 while master 1 strobes → slave sees only addr 0x00FF00, dat 0x3C, rw 0. Master 1 is granted after master 0 releases, then completes.
- Reset pulled low mid-read while OWN0 with stb high → all outputs 0 asynchronously, before the next clock edge. After release, IDLE and `o_grant`=0.
- `WB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, slave never acks → stb high for 8 cycles, then owner ack with data 0xFF and `o_timeout` pulse for 1 cycle. Bus is released and the other master can be granted.
- Without macro, same stimulus for 1000 cycles → grant held, no ack, `o_timeout`=0.
